dense_layer_sequencer: RTL and testbench

- Sequences the dense/activate pipeline through a complete training step for a network of up to MAX_LAYERS layers.
- Holds a per-layer configuration table (act_type, dense_type) and issues one layer at a time.
  - Forward pass: ascending layer order.
  - Backprop pass: descending layer order, if requested.
- Drives the act_type, dense_type, cost_type and backprop_controll buses that feed the dense/activate register stage.
- Spaces issues by PIPE_DEPTH cycles so each layer's result leaves the pipeline before the dependent layer is launched.

---
 rtl/dense_seq_pkg.sv | 37 +++
 rtl/dense_layer_cfg_table.sv | 29 ++
 rtl/dense_layer_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_dense_layer_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dense_seq_pkg.sv
// rtl/dense_seq_pkg.sv - shared types, widths and backprop_controll field layout for the dense layer sequencer
package dense_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        BWD  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int ACT_TYPE_SIZE   = 4;
    localparam int DENSE_TYPE_SIZE = 4;
    localparam int COST_TYPE_SIZE  = 8;
    localparam int BPC_SIZE        = 66;

    localparam int BP_EN_BIT = 65;
    localparam int LAST_BIT  = 64;
    localparam int IDX_LSB   = 32;
    localparam int LR_LSB    = 0;

    // Assemble {bp_en, last, layer_idx, lr}; the index arrives already zero-extended.
    function automatic logic [BPC_SIZE-1:0] pack_bpc(
        input logic        bp_en,
        input logic        last,
        input logic [31:0] idx,
        input logic [31:0] lr_v
    );
        logic [BPC_SIZE-1:0] v;
        v                 = '0;
        v[BP_EN_BIT]      = bp_en;
        v[LAST_BIT]       = last;
        v[IDX_LSB +: 32]  = idx;
        v[LR_LSB +: 32]   = lr_v;
        return v;
    endfunction

endpackage

// File: rtl/dense_layer_cfg_table.sv
// rtl/dense_layer_cfg_table.sv - per-layer {act, dense} register file, one write port, one async read port
module dense_layer_cfg_table #(
    parameter int MAX_LAYERS = 8,
    parameter int AW         = $clog2(MAX_LAYERS),
    parameter int ACT_W      = 4,
    parameter int DENSE_W    = 4
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [ACT_W-1:0]   wact,
    input  logic [DENSE_W-1:0] wdense,
    input  logic [AW-1:0]      raddr,
    output logic [ACT_W-1:0]   ract,
    output logic [DENSE_W-1:0] rdense
);

    logic [ACT_W+DENSE_W-1:0] mem_q [MAX_LAYERS];

    // Table contents are deliberately not reset; software loads them before a step.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= {wact, wdense};
        end
    end

    assign {ract, rdense} = mem_q[raddr];

endmodule

// File: rtl/dense_layer_sequencer.sv
// rtl/dense_layer_sequencer.sv - forward/backward layer issue sequencer; optional stall input via DENSE_LAYER_SEQUENCER_STALL_EN
module dense_layer_sequencer
    import dense_seq_pkg::*;
#(
    parameter int MAX_LAYERS             = 8,
    parameter int PIPE_DEPTH             = 4,
    parameter int act_type_size          = ACT_TYPE_SIZE,
    parameter int dense_type_size        = DENSE_TYPE_SIZE,
    parameter int cost_type_size         = COST_TYPE_SIZE,
    parameter int backprop_controll_size = BPC_SIZE
) (
    input  logic                              clk,
    input  logic                              rst,
`ifdef DENSE_LAYER_SEQUENCER_STALL_EN
    input  logic                              stall,
`endif
    input  logic                              cfg_we,
    input  logic [$clog2(MAX_LAYERS)-1:0]     cfg_addr,
    input  logic [act_type_size-1:0]          cfg_act,
    input  logic [dense_type_size-1:0]        cfg_dense,
    input  logic [$clog2(MAX_LAYERS):0]       num_layers,
    input  logic [cost_type_size-1:0]         cost_type,
    input  logic [31:0]                       lr,
    input  logic                              do_backprop,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic                              issue_valid,
    output logic [act_type_size-1:0]          act_type,
    output logic [dense_type_size-1:0]        dense_type,
    output logic [cost_type_size-1:0]         cost_type_out,
    output logic [backprop_controll_size-1:0] backprop_controll,
    output logic [$clog2(MAX_LAYERS)-1:0]     layer_idx
);

    localparam int IW = $clog2(MAX_LAYERS);
    localparam int NW = IW + 1;
    localparam int WW = $clog2(PIPE_DEPTH + 1);
    localparam logic [WW-1:0] WAIT_INIT = WW'(PIPE_DEPTH - 1);

    state_t                          state_q, state_d;
    logic [IW-1:0]                   idx_q, idx_d;
    logic [WW-1:0]                   wait_q, wait_d;
    logic [NW-1:0]                   n_q;
    logic                            bp_req_q;
    logic [31:0]                     lr_q;
    logic [cost_type_size-1:0]       cost_q;
    logic                            issue_q;
    logic [act_type_size-1:0]        act_q;
    logic [dense_type_size-1:0]      dense_q;
    logic [backprop_controll_size-1:0] bpc_q;

    logic                            accept;
    logic                            fire;
    logic                            fire_bp;
    logic                            fire_last;
    logic [31:0]                     lr_eff;
    logic                            stalled;
    logic [act_type_size-1:0]        rd_act;
    logic [dense_type_size-1:0]      rd_dense;

`ifdef DENSE_LAYER_SEQUENCER_STALL_EN
    assign stalled = stall;
`else
    assign stalled = 1'b0;
`endif

    // The table is read at the index about to be issued so the output register captures it on the issuing edge.
    dense_layer_cfg_table #(
        .MAX_LAYERS (MAX_LAYERS),
        .AW         (IW),
        .ACT_W      (act_type_size),
        .DENSE_W    (dense_type_size)
    ) u_cfg_table (
        .clk    (clk),
        .we     (cfg_we),
        .waddr  (cfg_addr),
        .wact   (cfg_act),
        .wdense (cfg_dense),
        .raddr  (idx_d),
        .ract   (rd_act),
        .rdense (rd_dense)
    );

    // Next-state: issue, then count PIPE_DEPTH-1 idle cycles down to zero before the next issue.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wait_d    = wait_q;
        accept    = 1'b0;
        fire      = 1'b0;
        fire_bp   = 1'b0;
        fire_last = 1'b0;
        lr_eff    = lr_q;
        case (state_q)
            IDLE: begin
                if (start && (num_layers != '0) && (num_layers <= NW'(MAX_LAYERS))) begin
                    accept    = 1'b1;
                    state_d   = FWD;
                    idx_d     = '0;
                    wait_d    = WAIT_INIT;
                    fire      = 1'b1;
                    fire_last = (num_layers == NW'(1));
                    lr_eff    = lr;
                end
            end
            FWD: begin
                if (!stalled) begin
                    if (wait_q != '0) begin
                        wait_d = wait_q - WW'(1);
                    end else if (NW'(idx_q) != (n_q - NW'(1))) begin
                        idx_d     = idx_q + IW'(1);
                        wait_d    = WAIT_INIT;
                        fire      = 1'b1;
                        fire_last = ((NW'(idx_q) + NW'(1)) == (n_q - NW'(1)));
                    end else if (bp_req_q) begin
                        // Backward pass starts on the layer the forward pass just finished.
                        state_d   = BWD;
                        wait_d    = WAIT_INIT;
                        fire      = 1'b1;
                        fire_bp   = 1'b1;
                        fire_last = (idx_q == '0);
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            BWD: begin
                if (!stalled) begin
                    if (wait_q != '0) begin
                        wait_d = wait_q - WW'(1);
                    end else if (idx_q != '0) begin
                        idx_d     = idx_q - IW'(1);
                        wait_d    = WAIT_INIT;
                        fire      = 1'b1;
                        fire_bp   = 1'b1;
                        fire_last = (idx_q == IW'(1));
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters, step parameters and the registered issue bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            wait_q   <= '0;
            n_q      <= '0;
            bp_req_q <= 1'b0;
            lr_q     <= '0;
            cost_q   <= '0;
            issue_q  <= 1'b0;
            act_q    <= '0;
            dense_q  <= '0;
            bpc_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            issue_q <= fire;
            if (accept) begin
                n_q      <= num_layers;
                bp_req_q <= do_backprop;
                lr_q     <= lr;
                cost_q   <= cost_type;
            end
            if (fire) begin
                act_q   <= rd_act;
                dense_q <= rd_dense;
                bpc_q   <= backprop_controll_size'(pack_bpc(fire_bp, fire_last, 32'(idx_d), lr_eff));
            end
        end
    end

    assign busy              = (state_q == FWD) || (state_q == BWD);
    assign done              = (state_q == DONE);
    assign issue_valid       = issue_q;
    assign act_type          = act_q;
    assign dense_type        = dense_q;
    assign cost_type_out     = cost_q;
    assign backprop_controll = bpc_q;
    assign layer_idx         = idx_q;

endmodule

// File: tb/tb_dense_layer_sequencer.sv
// tb/tb_dense_layer_sequencer.sv - self-checking bench for dense_layer_sequencer
module tb_dense_layer_sequencer;

    localparam int MAXL = 8;
    localparam int P    = 4;

    logic        clk;
    logic        rst;
`ifdef DENSE_LAYER_SEQUENCER_STALL_EN
    logic        stall;
`endif
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [3:0]  cfg_act;
    logic [3:0]  cfg_dense;
    logic [3:0]  num_layers;
    logic [7:0]  cost_type;
    logic [31:0] lr;
    logic        do_backprop;
    logic        start;
    logic        busy;
    logic        done;
    logic        issue_valid;
    logic [3:0]  act_type;
    logic [3:0]  dense_type;
    logic [7:0]  cost_type_out;
    logic [65:0] backprop_controll;
    logic [2:0]  layer_idx;

    logic [3:0]  tbl_act   [MAXL];
    logic [3:0]  tbl_dense [MAXL];

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        int          n;
        bit          bp;
        logic [31:0] lr;
        int          exp_done;
        int          exp_iss;
    } vec_t;

    vec_t vt[6];

    dense_layer_sequencer #(
        .MAX_LAYERS (MAXL),
        .PIPE_DEPTH (P)
    ) dut (
        .clk               (clk),
        .rst               (rst),
`ifdef DENSE_LAYER_SEQUENCER_STALL_EN
        .stall             (stall),
`endif
        .cfg_we            (cfg_we),
        .cfg_addr          (cfg_addr),
        .cfg_act           (cfg_act),
        .cfg_dense         (cfg_dense),
        .num_layers        (num_layers),
        .cost_type         (cost_type),
        .lr                (lr),
        .do_backprop       (do_backprop),
        .start             (start),
        .busy              (busy),
        .done              (done),
        .issue_valid       (issue_valid),
        .act_type          (act_type),
        .dense_type        (dense_type),
        .cost_type_out     (cost_type_out),
        .backprop_controll (backprop_controll),
        .layer_idx         (layer_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [65:0] got, input logic [65:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wr_cfg(input int a, input logic [3:0] av, input logic [3:0] dv);
        cfg_we    = 1'b1;
        cfg_addr  = 3'(a);
        cfg_act   = av;
        cfg_dense = dv;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        tbl_act[a]   = av;
        tbl_dense[a] = dv;
    endtask

    // Reference: cycle c (1 = cycle after start) issues step k=(c-1)/P when (c-1)%P==0;
    // steps 0..n-1 go up the layers, steps n..2n-1 come back down.
    task automatic run_seq(input int n, input bit bp, input logic [31:0] lr_v, input logic [7:0] ct,
                           input bit poke_start, input int abort_at,
                           output int done_at, output int n_iss);
        int exp_done, last_c, k, idx;
        bit legal, exp_iss, bpe, lst, have;
        logic [3:0] h_act, h_dense;
        legal    = (n >= 1) && (n <= MAXL);
        exp_done = legal ? 1 + P * n * (bp ? 2 : 1) : 0;
        last_c   = legal ? exp_done + 1 : 6;
        have     = 1'b0;
        h_act    = '0;
        h_dense  = '0;
        num_layers  = 4'(n);
        do_backprop = bp;
        lr          = lr_v;
        cost_type   = ct;
        start       = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        done_at = 0;
        n_iss   = 0;
        for (int c = 1; c <= last_c; c++) begin
            if (c == abort_at) break;
            start = poke_start && (c >= 2) && (c < 6);
            @(negedge clk);
            exp_iss = legal && (c < exp_done) && (((c - 1) % P) == 0);
            k   = (c - 1) / P;
            idx = (k < n) ? k : 2 * n - 1 - k;
            bpe = (k >= n);
            lst = bpe ? (idx == 0) : (idx == n - 1);
            if (issue_valid) n_iss++;
            if (done) done_at = c;
            chk("issue_valid", 66'(issue_valid), 66'(exp_iss));
            chk("busy", 66'(busy), 66'(legal && (c < exp_done)));
            chk("done", 66'(done), 66'(legal && (c == exp_done)));
            if (exp_iss) begin
                h_act   = tbl_act[idx];
                h_dense = tbl_dense[idx];
                have    = 1'b1;
                chk("act_type", 66'(act_type), 66'(h_act));
                chk("dense_type", 66'(dense_type), 66'(h_dense));
                chk("backprop_controll", backprop_controll, {bpe, lst, idx, lr_v});
                chk("layer_idx", 66'(layer_idx), 66'(idx));
            end else if (have) begin
                chk("act_hold", 66'(act_type), 66'(h_act));
                chk("dense_hold", 66'(dense_type), 66'(h_dense));
            end
            if (legal && (c <= exp_done)) chk("cost_type_out", 66'(cost_type_out), 66'(ct));
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    initial begin
        int d_at, ni, n, bp;
        rst = 1'b1;
`ifdef DENSE_LAYER_SEQUENCER_STALL_EN
        stall = 1'b0;
`endif
        cfg_we = 0; cfg_addr = 0; cfg_act = 0; cfg_dense = 0;
        num_layers = 0; cost_type = 0; lr = 0; do_backprop = 0; start = 0;
        @(negedge clk);
        chk("rst_busy", 66'(busy), 66'(0));
        chk("rst_done", 66'(done), 66'(0));
        chk("rst_issue", 66'(issue_valid), 66'(0));
        chk("rst_bpc", backprop_controll, 66'(0));
        chk("rst_act", 66'(act_type), 66'(0));
        chk("rst_idx", 66'(layer_idx), 66'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        wr_cfg(0, 4'd1, 4'd2);
        wr_cfg(1, 4'd3, 4'd1);
        wr_cfg(2, 4'd5, 4'd0);
        for (int i = 3; i < MAXL; i++) wr_cfg(i, 4'($urandom), 4'($urandom));

        vt[0] = '{3, 1'b0, 32'h0001_0000, 13, 3};
        vt[1] = '{3, 1'b1, 32'h0001_0000, 25, 6};
        vt[2] = '{1, 1'b1, 32'hdead_beef, 9, 2};
        vt[3] = '{8, 1'b1, 32'h1234_5678, 65, 16};
        vt[4] = '{0, 1'b0, 32'h0000_0001, 0, 0};
        vt[5] = '{9, 1'b1, 32'h0000_0002, 0, 0};
        for (int v = 0; v < 6; v++) begin
            run_seq(vt[v].n, vt[v].bp, vt[v].lr, 8'(8'h30 + v), (v == 1), 0, d_at, ni);
            chk("vec_done_cycle", 66'(d_at), 66'(vt[v].exp_done));
            chk("vec_issue_count", 66'(ni), 66'(vt[v].exp_iss));
        end

        // Reset asserted while BWD idx1 is in flight (issued at cycle 17).
        run_seq(3, 1'b1, 32'h0000_4000, 8'h5a, 1'b0, 18, d_at, ni);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 66'(busy), 66'(0));
        chk("midrst_issue", 66'(issue_valid), 66'(0));
        chk("midrst_done", 66'(done), 66'(0));
        chk("midrst_bpc", backprop_controll, 66'(0));
        chk("midrst_act", 66'(act_type), 66'(0));
        chk("midrst_dense", 66'(dense_type), 66'(0));
        chk("midrst_cost", 66'(cost_type_out), 66'(0));
        chk("midrst_idx", 66'(layer_idx), 66'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("postrst_done", 66'(done), 66'(0));
            chk("postrst_busy", 66'(busy), 66'(0));
            @(posedge clk); #1;
        end
        run_seq(3, 1'b1, 32'h0000_4000, 8'h5a, 1'b0, 0, d_at, ni);
        chk("fresh_done_cycle", 66'(d_at), 66'(25));
        chk("fresh_issue_count", 66'(ni), 66'(6));

        // Randomized steps over a freshly randomized table.
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < MAXL; i++) wr_cfg(i, 4'($urandom), 4'($urandom));
            n  = $urandom_range(1, MAXL);
            bp = $urandom_range(0, 1);
            run_seq(n, bp[0], $urandom, 8'($urandom), r[0], 0, d_at, ni);
            chk("rand_done_cycle", 66'(d_at), 66'(1 + P * n * (1 + bp)));
            chk("rand_issue_count", 66'(ni), 66'(n * (1 + bp)));
        end

`ifdef DENSE_LAYER_SEQUENCER_STALL_EN
        // Stall on cycles 4..6 pushes the idx1 issue from cycle 5 to 8.
        wr_cfg(0, 4'd1, 4'd2);
        wr_cfg(1, 4'd3, 4'd1);
        wr_cfg(2, 4'd5, 4'd0);
        num_layers = 4'd3; do_backprop = 1'b0; lr = 32'h1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            stall = (c >= 4) && (c <= 6);
            @(negedge clk);
            chk("stall_issue", 66'(issue_valid), 66'((c == 1) || (c == 8) || (c == 12)));
            chk("stall_done", 66'(done), 66'(c == 16));
            if (c == 8) chk("stall_idx1", 66'(layer_idx), 66'(1));
            if (c == 12) chk("stall_idx2_act", 66'(act_type), 66'(5));
            @(posedge clk); #1;
        end
        stall = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
